// File: rtl/cb_vm_seq.sv
// Sequencer for the covariance-buffer vector-move path: walks a range of row groups,
// issues three CB accesses per group (dense or sparse), then drains the L-deep shift.
module cb_vm_seq #(
  parameter int L       = 4,
  parameter int CB_AW   = 19,
  parameter int ROW_LEN = 10
) (
  input  logic               clk,
  input  logic               sys_rst,
  input  logic               start,
  input  logic               mode,
  input  logic [ROW_LEN-1:0] group_base,
  input  logic [ROW_LEN-1:0] group_num,
  input  logic               hold,
  input  logic [CB_AW-1:0]   cb_base_addr,
  output logic               busy,
  output logic               done,
  output logic [ROW_LEN-1:0] group_cnt,
  output logic               agd_en,
  output logic               ena_new,
  output logic [CB_AW-1:0]   addr_new
);

  localparam int DW = (L > 1) ? $clog2(L) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, GAP, DRAIN, DONE} state_t;

  state_t             state, state_n;
  logic               mode_q;
  logic [ROW_LEN-1:0] base_q, num_q;
  logic [ROW_LEN-1:0] g, g_n;
  logic [ROW_LEN:0]   g_inc;
  logic [1:0]         k, k_n;
  logic [DW-1:0]      drn, drn_n;
  logic               held, last_grp, issue_n;
  logic [ROW_LEN-1:0] grp_base_sel;

  // hold only freezes the sequencing states; IDLE and DONE always advance
  assign held     = hold && (state == LOAD || state == ISSUE || state == GAP || state == DRAIN);
  assign g_inc    = {1'b0, g} + {{ROW_LEN{1'b0}}, 1'b1};
  assign last_grp = g_inc >= {1'b0, num_q};
  assign issue_n  = !held && (state_n == ISSUE);
  assign grp_base_sel = (state == IDLE) ? group_base : base_q;

  always_comb begin
    state_n = state;
    g_n     = g;
    k_n     = k;
    drn_n   = drn;
    if (!held) begin
      case (state)
        IDLE: if (start) begin
          g_n     = '0;
          k_n     = '0;
          drn_n   = '0;
          state_n = (group_num == '0) ? DONE : LOAD;
        end
        LOAD: begin
          state_n = ISSUE;
          k_n     = '0;
        end
        ISSUE, GAP: begin
          if (state == ISSUE && mode_q) begin
            state_n = GAP;
          end else if (k != 2'd2) begin
            k_n     = k + 2'd1;
            state_n = ISSUE;
          end else if (last_grp) begin
            state_n = DRAIN;
            drn_n   = '0;
          end else begin
            state_n = LOAD;
            g_n     = g_inc[ROW_LEN-1:0];
          end
        end
        DRAIN: begin
          if (drn == DW'(L - 1)) state_n = DONE;
          else                   drn_n   = drn + DW'(1);
        end
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // outputs are registered from the next-state values so they line up with the state they name
  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state     <= IDLE;
      mode_q    <= 1'b0;
      base_q    <= '0;
      num_q     <= '0;
      g         <= '0;
      k         <= '0;
      drn       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      group_cnt <= '0;
      agd_en    <= 1'b0;
      ena_new   <= 1'b0;
      addr_new  <= '0;
    end else begin
      state <= state_n;
      g     <= g_n;
      k     <= k_n;
      drn   <= drn_n;
      if (state == IDLE && start) begin
        mode_q <= mode;
        base_q <= group_base;
        num_q  <= group_num;
      end
      if (!held && state_n == LOAD) group_cnt <= grp_base_sel + g_n;
      busy     <= (state_n == LOAD) || (state_n == ISSUE) || (state_n == GAP) || (state_n == DRAIN);
      done     <= (state_n == DONE);
      agd_en   <= held ? agd_en : ((state_n == ISSUE || state_n == GAP) && k_n == 2'd1);
      ena_new  <= issue_n;
      addr_new <= issue_n ? cb_base_addr + CB_AW'(k_n) : '0;
    end
  end

endmodule
